multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: one state per instruction phase,
// with datapath controls decoded combinationally from the current state.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC + 4
// DECODE | register read, branch target into ALU-out
// MEMADR | effective address for lw/sw
// MEMRD  | data read, waits on memory
// MEMWB  | load data into rt
// MEMWR  | data write, waits on memory
// EXEC   | R-type ALU operation
// ALUWB  | R-type result into rd
// BRANCH | compare and conditional PC update
// ADDIEX | rs + sign-imm
// ADDIWB | addi result into rt
// JUMP   | PC <= jump target
module multicycle_ctrl #(
    parameter int MEM_WAIT = 1,
    parameter int EN_BNE   = 1,
    parameter int EN_ADDI  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state_r;

    logic mem_ok;
    logic is_mem;
    logic is_rtype;
    logic is_branch;
    logic is_addi;
    logic is_jump;

    // Without wait states every memory access is assumed to finish in one cycle.
    assign mem_ok    = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_rtype  = (op == OP_RTYPE);
    assign is_branch = (op == OP_BEQ) || ((EN_BNE != 0) && (op == OP_BNE));
    assign is_addi   = (EN_ADDI != 0) && (op == OP_ADDI);
    assign is_jump   = (op == OP_J);

    assign state = state_r;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH:  if (mem_ok) state_r <= DECODE;
                DECODE: begin
                    if (is_mem)         state_r <= MEMADR;
                    else if (is_rtype)  state_r <= EXEC;
                    else if (is_branch) state_r <= BRANCH;
                    else if (is_addi)   state_r <= ADDIEX;
                    else if (is_jump)   state_r <= JUMP;
                    else                state_r <= FETCH;
                end
                MEMADR: state_r <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (mem_ok) state_r <= MEMWB;
                MEMWB:  state_r <= FETCH;
                MEMWR:  if (mem_ok) state_r <= FETCH;
                EXEC:   state_r <= ALUWB;
                ALUWB:  state_r <= FETCH;
                BRANCH: state_r <= FETCH;
                ADDIEX: state_r <= ADDIWB;
                ADDIWB: state_r <= FETCH;
                JUMP:   state_r <= FETCH;
                default: state_r <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 3'b000;
        illegal_op  = 1'b0;

        case (state_r)
            FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                // Reset holds the PC and IR even though FETCH is displayed.
                ir_write    = mem_ok & RST;
                pc_write    = mem_ok & RST;
            end
            DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
                illegal_op  = ~(is_mem | is_rtype | is_branch | is_addi | is_jump);
            end
            MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default: begin
                        alu_control = 3'b010;
                        illegal_op  = 1'b1;
                    end
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                if (op == OP_BEQ)  pc_write = zero;
                else if (is_branch) pc_write = ~zero;
            end
            ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: default build, a build without bne/addi,
// and a build without memory wait states, all sharing one stimulus.
module tb_multicycle_ctrl;

    logic       CLK;
    logic       RST;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req, iord, mem_write, ir_write, pc_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    logic [20:0] oa;
    logic [20:0] ob;
    logic [20:0] oc;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [20:0] RST_VEC = 21'b1_0000_0000_01_00_010_0_0000;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    assign oa = {mem_req, iord, mem_write, ir_write, pc_write, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, state};

    multicycle_ctrl dut_a (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
    );

    multicycle_ctrl #(.MEM_WAIT(1), .EN_BNE(0), .EN_ADDI(0)) dut_b (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(ob[20]), .iord(ob[19]), .mem_write(ob[18]), .ir_write(ob[17]),
        .pc_write(ob[16]), .reg_write(ob[15]), .reg_dst(ob[14]), .mem_to_reg(ob[13]),
        .alu_src_a(ob[12]), .alu_src_b(ob[11:10]), .pc_src(ob[9:8]),
        .alu_control(ob[7:5]), .illegal_op(ob[4]), .state(ob[3:0])
    );

    multicycle_ctrl #(.MEM_WAIT(0)) dut_c (
        .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .mem_ready(1'b0),
        .mem_req(oc[20]), .iord(oc[19]), .mem_write(oc[18]), .ir_write(oc[17]),
        .pc_write(oc[16]), .reg_write(oc[15]), .reg_dst(oc[14]), .mem_to_reg(oc[13]),
        .alu_src_a(oc[12]), .alu_src_b(oc[11:10]), .pc_src(oc[9:8]),
        .alu_control(oc[7:5]), .illegal_op(oc[4]), .state(oc[3:0])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; op = 6'b111111; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        RST = 1'b0;
        #1;
        n_checks++;
        if (oa !== RST_VEC) begin
            n_fail++; $display("FAIL reset_a got=%b exp=%b", oa, RST_VEC);
        end
        n_checks++;
        if (ob !== RST_VEC) begin
            n_fail++; $display("FAIL reset_b got=%b exp=%b", ob, RST_VEC);
        end
        n_checks++;
        if (oc !== RST_VEC) begin
            n_fail++; $display("FAIL reset_c got=%b exp=%b", oc, RST_VEC);
        end
        step();
        n_checks++;
        if (oa !== RST_VEC) begin
            n_fail++; $display("FAIL reset_hold got=%b exp=%b", oa, RST_VEC);
        end
    endtask

    task automatic test_fetch_wait_and_jump();
        op = OP_J; mem_ready = 1'b0;
        do_reset();
        n_checks++;
        if ({state, ir_write, pc_write, mem_req} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL fetch_wait st=%0d irw=%b pcw=%b req=%b exp st=0 0 0 1",
                               state, ir_write, pc_write, mem_req);
        end
        n_checks++;
        if ({oc[17], oc[16]} !== 2'b11) begin
            n_fail++; $display("FAIL nowait_fetch irw/pcw got=%b exp=11", {oc[17], oc[16]});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (state !== 4'd0) begin
                n_fail++; $display("FAIL fetch_hold cyc=%0d st=%0d exp=0", i, state);
            end
            n_checks++;
            if (i == 0 && oc[3:0] !== 4'd1) begin
                n_fail++; $display("FAIL nowait_j_decode st=%0d exp=1", oc[3:0]);
            end else if (i == 1 && {oc[3:0], oc[16], oc[9:8]} !== {4'd11, 1'b1, 2'b10}) begin
                n_fail++; $display("FAIL nowait_j_jump st=%0d pcw=%b pcsrc=%b exp 11 1 10",
                                   oc[3:0], oc[16], oc[9:8]);
            end else if (i == 2 && oc[3:0] !== 4'd0) begin
                n_fail++; $display("FAIL nowait_j_done st=%0d exp=0", oc[3:0]);
            end
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({ir_write, pc_write} !== 2'b11) begin
            n_fail++; $display("FAIL fetch_ready irw/pcw got=%b exp=11", {ir_write, pc_write});
        end
        step();
        step();
        n_checks++;
        if ({state, pc_write, pc_src} !== {4'd11, 1'b1, 2'b10}) begin
            n_fail++; $display("FAIL jump st=%0d pcw=%b pcsrc=%b exp 11 1 10", state, pc_write, pc_src);
        end
        step();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL jump_done st=%0d exp=0", state);
        end
    endtask

    task automatic test_lw();
        // {state, reg_write, mem_to_reg, iord, mem_req} per cycle
        logic [7:0] exp_lw [6] = '{8'b0000_0001, 8'b0001_0000, 8'b0010_0000,
                                   8'b0011_0011, 8'b0100_1100, 8'b0000_0001};
        op = OP_LW; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({state, reg_write, mem_to_reg, iord, mem_req} !== exp_lw[i]) begin
                n_fail++; $display("FAIL lw cyc=%0d got=%b exp=%b", i,
                                   {state, reg_write, mem_to_reg, iord, mem_req}, exp_lw[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_sw_wait();
        op = OP_SW; mem_ready = 1'b1;
        do_reset();
        step();
        step();
        mem_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({state, mem_write, reg_write, iord} !== {4'd5, 1'b1, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL sw_wait cyc=%0d st=%0d mw=%b rw=%b iord=%b exp 5 1 0 1",
                                   k, state, mem_write, reg_write, iord);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({state, mem_write, reg_write} !== {4'd5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sw_last st=%0d mw=%b rw=%b exp 5 1 0", state, mem_write, reg_write);
        end
        step();
        n_checks++;
        if ({state, mem_write, reg_write} !== {4'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sw_done st=%0d mw=%b rw=%b exp 0 0 0", state, mem_write, reg_write);
        end
    endtask

    task automatic test_branch();
        logic [5:0] br_op [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic       br_z  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       br_pw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            op = br_op[i]; zero = br_z[i]; mem_ready = 1'b1;
            do_reset();
            step();
            n_checks++;
            if (illegal_op !== 1'b0) begin
                n_fail++; $display("FAIL br_decode_ill case=%0d got=%b exp=0", i, illegal_op);
            end
            n_checks++;
            if (ob[4] !== (br_op[i] == OP_BNE)) begin
                n_fail++; $display("FAIL nobne_decode_ill case=%0d got=%b exp=%b", i, ob[4],
                                   br_op[i] == OP_BNE);
            end
            step();
            n_checks++;
            if ({state, pc_write, pc_src, alu_control, alu_src_a, alu_src_b} !==
                {4'd8, br_pw[i], 2'b01, 3'b110, 1'b1, 2'b00}) begin
                n_fail++; $display("FAIL branch case=%0d st=%0d pcw=%b pcsrc=%b aluc=%b exp 8 %b 01 110",
                                   i, state, pc_write, pc_src, alu_control, br_pw[i]);
            end
            n_checks++;
            if (ob[3:0] !== ((br_op[i] == OP_BNE) ? 4'd0 : 4'd8)) begin
                n_fail++; $display("FAIL nobne_state case=%0d got=%0d", i, ob[3:0]);
            end
            step();
            n_checks++;
            if (state !== 4'd0) begin
                n_fail++; $display("FAIL branch_done case=%0d st=%0d exp=0", i, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        logic [2:0] alu [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        logic       ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            op = 6'b000000; funct = fn[i]; mem_ready = 1'b1;
            do_reset();
            step();
            step();
            n_checks++;
            if ({state, alu_control, illegal_op, alu_src_a, alu_src_b} !==
                {4'd6, alu[i], ill[i], 1'b1, 2'b00}) begin
                n_fail++; $display("FAIL exec funct=%b st=%0d aluc=%b ill=%b exp 6 %b %b",
                                   fn[i], state, alu_control, illegal_op, alu[i], ill[i]);
            end
            step();
            n_checks++;
            if ({state, reg_write, reg_dst, mem_to_reg, illegal_op} !== {4'd7, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL aluwb funct=%b st=%0d rw=%b rd=%b m2r=%b exp 7 1 1 0",
                                   fn[i], state, reg_write, reg_dst, mem_to_reg);
            end
            step();
            n_checks++;
            if (state !== 4'd0) begin
                n_fail++; $display("FAIL rtype_done funct=%b st=%0d exp=0", fn[i], state);
            end
        end
    endtask

    task automatic test_addi();
        op = OP_ADDI; mem_ready = 1'b1;
        do_reset();
        step();
        n_checks++;
        if ({ob[4], illegal_op} !== 2'b10) begin
            n_fail++; $display("FAIL addi_decode_ill b/a got=%b exp=10", {ob[4], illegal_op});
        end
        step();
        n_checks++;
        if ({state, alu_src_a, alu_src_b, alu_control, ob[3:0]} !== {4'd9, 1'b1, 2'b10, 3'b010, 4'd0}) begin
            n_fail++; $display("FAIL addiex st=%0d asa=%b asb=%b aluc=%b b_st=%0d exp 9 1 10 010 0",
                               state, alu_src_a, alu_src_b, alu_control, ob[3:0]);
        end
        step();
        n_checks++;
        if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL addiwb st=%0d rw=%b rd=%b m2r=%b exp 10 1 0 0",
                               state, reg_write, reg_dst, mem_to_reg);
        end
        step();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL addi_done st=%0d exp=0", state);
        end
    endtask

    task automatic test_illegal_op();
        op = 6'b111111; mem_ready = 1'b1;
        do_reset();
        step();
        n_checks++;
        if ({state, illegal_op} !== {4'd1, 1'b1}) begin
            n_fail++; $display("FAIL illegal_decode st=%0d ill=%b exp 1 1", state, illegal_op);
        end
        step();
        n_checks++;
        if ({state, illegal_op} !== {4'd0, 1'b0}) begin
            n_fail++; $display("FAIL illegal_return st=%0d ill=%b exp 0 0", state, illegal_op);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [5:0] ops [2] = '{OP_LW, OP_SW};
        logic [3:0] wst [2] = '{4'd3, 4'd5};
        for (int i = 0; i < 2; i++) begin
            op = ops[i]; mem_ready = 1'b1;
            do_reset();
            step();
            step();
            mem_ready = 1'b0;
            step();
            step();
            n_checks++;
            if (state !== wst[i]) begin
                n_fail++; $display("FAIL mid_wait op=%b st=%0d exp=%0d", ops[i], state, wst[i]);
            end
            #2;
            RST = 1'b0;
            #1;
            n_checks++;
            if ({state, reg_write, mem_write, ir_write} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL async_reset op=%b st=%0d rw=%b mw=%b irw=%b exp 0 0 0 0",
                                   ops[i], state, reg_write, mem_write, ir_write);
            end
            mem_ready = 1'b1;
            step();
            n_checks++;
            if ({state, reg_write, mem_write, pc_write} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL reset_held op=%b st=%0d rw=%b mw=%b pcw=%b exp 0 0 0 0",
                                   ops[i], state, reg_write, mem_write, pc_write);
            end
            RST = 1'b1;
            #1;
            step();
            n_checks++;
            if (state !== 4'd1) begin
                n_fail++; $display("FAIL refetch op=%b st=%0d exp=1", ops[i], state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_wait_and_jump();
        test_lw();
        test_sw_wait();
        test_branch();
        test_rtype();
        test_addi();
        test_illegal_op();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
